data_cache_ctrl: RTL and testbench



---
 rtl/data_cache_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_cache_ctrl
//  Purpose  : Miss / write-back controller for a direct-mapped, write-allocate,
//             write-back data cache. Drives the tag RAM, sequences dirty-line
//             write-back and line refill over a word-serial req/ack memory
//             port, and stalls the MEM stage until the access hits.
//  Options  : DCACHE_STATS_EN - adds saturating hit_count / miss_count ports.
//  Revision : 1.0 - initial release
// ============================================================================
module data_cache_ctrl #(
   parameter int INDEX_BITS    = 6,
   parameter int WORD_OFF_BITS = 2,
   parameter int TAG_BITS      = 22
) (
   input  logic                     clock,
   input  logic                     reset_n,
   // MEM-stage request
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [31:0]              cpu_addr,
   output logic                     cpu_stall,
   // Tag RAM
   output logic                     tag_we,
   output logic [INDEX_BITS-1:0]    tag_index,
   output logic                     tag_valid_wr,
   output logic                     tag_dirty_wr,
   output logic [TAG_BITS-1:0]      tag_tag_wr,
   input  logic                     tag_valid_rd,
   input  logic                     tag_dirty_rd,
   input  logic [TAG_BITS-1:0]      tag_tag_rd,
   // Data array word select / refill write
   output logic [WORD_OFF_BITS-1:0] line_word,
   output logic                     refill_we,
   // Word-serial memory port
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [31:0]              mem_addr,
   input  logic                     mem_ack
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]              hit_count,
   output logic [31:0]              miss_count
`endif
);

   // Controller states
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_REFILL    = 2'd2,
      S_UPDATE    = 2'd3
   } state_t;

   // Last word of a line and the counter increment
   localparam logic [WORD_OFF_BITS-1:0] c_CNT_MAX = '1;
   localparam logic [WORD_OFF_BITS-1:0] c_CNT_ONE = WORD_OFF_BITS'(1);

   state_t                     r_state;
   logic [WORD_OFF_BITS-1:0]   r_cnt;

   logic [TAG_BITS-1:0]        w_cpu_tag;
   logic [INDEX_BITS-1:0]      w_index;
   logic                       w_hit;
   logic                       w_last;
   logic                       w_unused;

   // Address field split: tag | index | word | byte
   assign w_cpu_tag = cpu_addr[31 -: TAG_BITS];
   assign w_index   = cpu_addr[2 + WORD_OFF_BITS +: INDEX_BITS];
   assign tag_index = w_index;

   // Byte offset within a word is irrelevant to the controller
   assign w_unused  = ^cpu_addr[1:0];

   // Hit when the stored line is valid and its tag matches the request
   assign w_hit  = tag_valid_rd && (tag_tag_rd == w_cpu_tag);
   assign w_last = (r_cnt == c_CNT_MAX);

   // State and word counter; cnt wraps to 0 after the last word of a line
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cpu_req && !w_hit) begin
                  r_cnt <= '0;
                  if (tag_valid_rd && tag_dirty_rd) begin
                     r_state <= S_WRITEBACK;
                  end else begin
                     r_state <= S_REFILL;
                  end
               end
            end
            S_WRITEBACK: begin
               if (mem_ack) begin
                  r_cnt <= r_cnt + c_CNT_ONE;
                  if (w_last) begin
                     r_state <= S_REFILL;
                  end
               end
            end
            S_REFILL: begin
               if (mem_ack) begin
                  r_cnt <= r_cnt + c_CNT_ONE;
                  if (w_last) begin
                     r_state <= S_UPDATE;
                  end
               end
            end
            S_UPDATE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Output decode; every output except tag_index is forced low while reset
   // is asserted so an in-flight transfer is dropped immediately
   always_comb begin
      cpu_stall    = 1'b0;
      tag_we       = 1'b0;
      tag_valid_wr = 1'b0;
      tag_dirty_wr = 1'b0;
      tag_tag_wr   = '0;
      line_word    = '0;
      refill_we    = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      if (reset_n) begin
         case (r_state)
            S_IDLE: begin
               if (cpu_req) begin
                  if (w_hit) begin
                     // Store hit marks the line dirty, tag unchanged
                     if (cpu_we) begin
                        tag_we       = 1'b1;
                        tag_valid_wr = 1'b1;
                        tag_dirty_wr = 1'b1;
                        tag_tag_wr   = tag_tag_rd;
                     end
                  end else begin
                     cpu_stall = 1'b1;
                  end
               end
            end
            S_WRITEBACK: begin
               // Victim address is rebuilt from the stored tag
               cpu_stall = 1'b1;
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {tag_tag_rd, w_index, r_cnt, 2'b00};
               line_word = r_cnt;
            end
            S_REFILL: begin
               cpu_stall = 1'b1;
               mem_req   = 1'b1;
               mem_addr  = {w_cpu_tag, w_index, r_cnt, 2'b00};
               line_word = r_cnt;
               refill_we = mem_ack;
            end
            S_UPDATE: begin
               // Install the new line clean; a store retry dirties it
               cpu_stall    = 1'b1;
               tag_we       = 1'b1;
               tag_valid_wr = 1'b1;
               tag_dirty_wr = 1'b0;
               tag_tag_wr   = w_cpu_tag;
            end
            default: begin
               cpu_stall = 1'b1;
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic w_hit_evt;
   logic w_miss_evt;

   assign w_hit_evt  = (r_state == S_IDLE) && cpu_req && w_hit;
   assign w_miss_evt = (r_state == S_IDLE) && cpu_req && !w_hit;

   // Saturating hit / miss counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (w_hit_evt && (hit_count != '1)) begin
            hit_count <= hit_count + 32'd1;
         end
         if (w_miss_evt && (miss_count != '1)) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_cache_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_data_cache_ctrl
//  Purpose  : Self-checking bench for data_cache_ctrl: directed scenarios plus
//             randomized loads/stores against a line-level cache model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache_ctrl;

   localparam int IB = 6;
   localparam int WB = 2;
   localparam int TB = 22;
   localparam int NW = 1 << WB;

   logic           clock = 1'b0;
   logic           reset_n = 1'b0;
   logic           cpu_req = 1'b0;
   logic           cpu_we = 1'b0;
   logic [31:0]    cpu_addr = '0;
   logic           cpu_stall;
   logic           tag_we;
   logic [IB-1:0]  tag_index;
   logic           tag_valid_wr;
   logic           tag_dirty_wr;
   logic [TB-1:0]  tag_tag_wr;
   logic           tag_valid_rd;
   logic           tag_dirty_rd;
   logic [TB-1:0]  tag_tag_rd;
   logic [WB-1:0]  line_word;
   logic           refill_we;
   logic           mem_req;
   logic           mem_we;
   logic [31:0]    mem_addr;
   logic           mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0]    hit_count;
   logic [31:0]    miss_count;
`endif

   data_cache_ctrl #(.INDEX_BITS(IB), .WORD_OFF_BITS(WB), .TAG_BITS(TB)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_stall    (cpu_stall),
      .tag_we       (tag_we),
      .tag_index    (tag_index),
      .tag_valid_wr (tag_valid_wr),
      .tag_dirty_wr (tag_dirty_wr),
      .tag_tag_wr   (tag_tag_wr),
      .tag_valid_rd (tag_valid_rd),
      .tag_dirty_rd (tag_dirty_rd),
      .tag_tag_rd   (tag_tag_rd),
      .line_word    (line_word),
      .refill_we    (refill_we),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   always #5 clock = ~clock;

   // Tag RAM seen by the DUT: combinational read, clocked write
   logic          ram_v [0:(1<<IB)-1];
   logic          ram_d [0:(1<<IB)-1];
   logic [TB-1:0] ram_t [0:(1<<IB)-1];

   assign tag_valid_rd = ram_v[tag_index];
   assign tag_dirty_rd = ram_d[tag_index];
   assign tag_tag_rd   = ram_t[tag_index];

   always @(posedge clock) begin
      if (tag_we) begin
         ram_v[tag_index] <= tag_valid_wr;
         ram_d[tag_index] <= tag_dirty_wr;
         ram_t[tag_index] <= tag_tag_wr;
      end
   end

   // Line-level reference state of the cache
   logic          m_v [0:(1<<IB)-1];
   logic          m_d [0:(1<<IB)-1];
   logic [TB-1:0] m_t [0:(1<<IB)-1];
   int            exp_hits = 0;
   int            exp_miss = 0;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One CPU access: expected memory traffic derived from the model, then
   // the DUT is serviced until the stall drops.
   // mode 0: acknowledge every second request cycle; mode 1: random acks
   task automatic access(input logic we, input logic [31:0] addr, input int mode);
      logic [IB-1:0] idx;
      logic [TB-1:0] tg;
      logic [WB-1:0] wl;
      logic [32:0]   q[$];
      logic [32:0]   e;
      bit            hit, done, tog, ack;
      int            req_cyc, stall_cyc, guard;
      idx = addr[WB+2 +: IB];
      tg  = addr[31 -: TB];
      hit = m_v[idx] && (m_t[idx] == tg);
      if (!hit) begin
         if (m_v[idx] && m_d[idx]) begin
            for (int w = 0; w < NW; w++) begin
               wl = w[WB-1:0];
               q.push_back({1'b1, m_t[idx], idx, wl, 2'b00});
            end
         end
         for (int w = 0; w < NW; w++) begin
            wl = w[WB-1:0];
            q.push_back({1'b0, tg, idx, wl, 2'b00});
         end
      end
      @(negedge clock);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
      done = 0; tog = 0; req_cyc = 0; stall_cyc = 0; guard = 0;
      while (!done && guard < 400) begin
         guard++;
         #1;
         if (!cpu_stall) begin
            done = 1;
            chk("end_mem_req", mem_req, 0);
            chk("end_tag_we", tag_we, we);
            if (we) begin
               chk("st_valid", tag_valid_wr, 1);
               chk("st_dirty", tag_dirty_wr, 1);
               chk("st_tag", tag_tag_wr, tg);
            end
         end else begin
            stall_cyc++;
            if (tag_we) begin
               chk("upd_valid", tag_valid_wr, 1);
               chk("upd_dirty", tag_dirty_wr, 0);
               chk("upd_tag", tag_tag_wr, tg);
            end
            if (mem_req) begin
               req_cyc++;
               ack = (mode == 0) ? tog : ($urandom_range(0, 2) == 0);
               tog = !tog;
               if (ack) begin
                  if (q.size() == 0) begin
                     chk("extra_req", 1, 0);
                  end else begin
                     e = q.pop_front();
                     chk("mem_we", mem_we, e[32]);
                     chk("mem_addr", mem_addr, e[31:0]);
                     chk("line_word", line_word, e[3:2]);
                  end
                  mem_ack = 1'b1;
                  #1;
                  chk("refill_we", refill_we, !mem_we);
               end
            end
         end
         @(posedge clock);
         #1;
         mem_ack = 1'b0;
         if (!done) @(negedge clock);
      end
      cpu_req = 1'b0; cpu_we = 1'b0;
      chk("timeout", done, 1);
      chk("words_left", q.size(), 0);
      chk("stall_cycles", stall_cyc, hit ? 0 : req_cyc + 2);
      // Model update: after any access the line is present with the new tag
      if (!hit) begin
         m_d[idx] = we;
         exp_miss++;
      end else if (we) begin
         m_d[idx] = 1'b1;
      end
      m_v[idx] = 1'b1;
      m_t[idx] = tg;
      exp_hits++;
      chk("ram_valid", ram_v[idx], m_v[idx]);
      chk("ram_dirty", ram_d[idx], m_d[idx]);
      chk("ram_tag", ram_t[idx], m_t[idx]);
   endtask

   logic [31:0] ra;

   initial begin
      for (int i = 0; i < (1<<IB); i++) begin
         ram_v[i] = 1'b0; ram_d[i] = 1'($urandom_range(0, 1)); ram_t[i] = TB'($urandom);
         m_v[i]   = 1'b0; m_d[i]   = ram_d[i];                 m_t[i]   = ram_t[i];
      end

      // Reset state: outputs low, tag_index still follows the address
      cpu_req = 1'b1; cpu_addr = 32'h0000_0150;
      #12;
      chk("rst_stall", cpu_stall, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_tag_we", tag_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_refill_we", refill_we, 0);
      chk("rst_tag_index", tag_index, 6'h15);
      cpu_req = 1'b0;
      @(negedge clock); reset_n = 1'b1;
      @(negedge clock); #1;
      chk("idle_stall", cpu_stall, 0);
      chk("idle_mem_req", mem_req, 0);
      chk("idle_tag_we", tag_we, 0);

      // Directed: cold load, store hit, dirty eviction, clean eviction
      access(1'b0, 32'h0000_0100, 0);
      access(1'b1, 32'h0000_0100, 0);
      access(1'b0, 32'h0000_1100, 0);
      access(1'b0, 32'h0000_2100, 0);

      // Reset during the second refill word
      @(negedge clock);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200;
      @(negedge clock); #1;
      chk("rf_req_w0", mem_req, 1);
      mem_ack = 1'b1;
      @(posedge clock); #1; mem_ack = 1'b0;
      @(negedge clock); #1;
      chk("rf_req_w1", mem_req, 1);
      chk("rf_word_w1", line_word, 1);
      reset_n = 1'b0;
      #1;
      chk("arst_mem_req", mem_req, 0);
      chk("arst_stall", cpu_stall, 0);
      chk("arst_ram_v", ram_v[6'h20], 0);
      cpu_req = 1'b0;
      exp_hits = 0; exp_miss = 0;
      @(negedge clock); reset_n = 1'b1;

      // Restarted load from word 0, then three hits
      access(1'b0, 32'h0000_0200, 0);
      access(1'b0, 32'h0000_0204, 1);
      access(1'b1, 32'h0000_0208, 1);
      access(1'b0, 32'h0000_020C, 1);
`ifdef DCACHE_STATS_EN
      chk("stat_hits", hit_count, exp_hits);
      chk("stat_miss", miss_count, exp_miss);
`endif

      // Random loads/stores over a small tag/index set to force conflicts
      for (int n = 0; n < 150; n++) begin
         ra = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
         access(1'($urandom_range(0, 1)), ra, 1);
      end
`ifdef DCACHE_STATS_EN
      chk("stat_hits_end", hit_count, exp_hits);
      chk("stat_miss_end", miss_count, exp_miss);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
